sd_cmd_engine: RTL
==================

Name: sd_cmd_engine

Overview:
- Parametrised next-generation SD command-line controller.
- Accepts a command (index + argument) from host control and builds the 48-bit frame with CRC7. Shifts the frame out on the CMD line, then waits a programmable number of bit-times for the card's start bit.
- Captures a short (48-bit) or long (136-bit) response, or none, selected per command. Reports done/timeout/CRC/framing status.
- Sits between host control and the CMD pad; replaces separate serializer/deserializer sequencing.

Parameters:
- TIMEOUT_W, 8, width of the timeout_cycles input; max wait = 2^TIMEOUT_W-1 bit-times.
- NCC_BITS, 8, bit-times of CMD high (oe=1, out=1) driven after a response or no-response command before cmd_ready reasserts.
- TURN_BITS, 2, bit-times of CMD released (oe=0) after the end bit before response sampling starts.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- bit_en  in  1  one-cycle strobe, one per SD bit-time; all CMD-line activity advances only on bit_en=1.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- rsp_type  in  2  00 none, 01 short 48-bit, 10 long 136-bit, 11 short with busy-ignore (treated as 01).
- timeout_cycles  in  TIMEOUT_W  bit-times to wait for the start bit; 0 is treated as 1.
- cmd_out  out  1  CMD line drive value.
- cmd_oe  out  1  CMD output enable.
- cmd_in  in  1  CMD line sampled value (already synchronised).
- rsp_data  out  136  captured response, right-aligned; short responses occupy [47:0] with [135:48]=0.
- done  out  1  one-cycle pulse: command (and response, if any) finished.
- timeout  out  1  status, valid with done.
- crc_err  out  1  status, valid with done.
- end_err  out  1  status, valid with done: end bit was not 1.

Behaviour:
- Reset values: cmd_ready=0 during reset and 1 the cycle after; cmd_out=1; cmd_oe=0; rsp_data=0; done=0; status flags=0; state IDLE.
- Reset mid-operation aborts immediately, with no done pulse.
- Handshake: command accepted on clock where cmd_valid&&cmd_ready. cmd_index, cmd_arg, rsp_type and timeout_cycles are latched that cycle. cmd_ready drops the next cycle.
- Frame: {0,1,index[5:0],arg[31:0],crc7[6:0],1}. CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- States:
  - IDLE: cmd_oe=0, cmd_out=1. On accept -> TX and clear status flags.
  - TX: on each bit_en, drive the next frame bit MSB-first with cmd_oe=1. First bit appears on the first bit_en after accept. After bit 47 -> TURN if rsp_type!=00, else NCC.
  - TURN: cmd_oe=0 for TURN_BITS bit_en strobes -> WAIT.
  - WAIT: counter increments on each bit_en.
    - cmd_in=0 sampled on bit_en -> RX; the start bit is counted as response bit 0.
    - Counter reaching timeout_cycles with no start bit -> timeout=1 -> NCC.
    - If the start bit and the last count coincide, the start bit wins.
  - RX: shift cmd_in on each bit_en until 48 or 136 bits total.
    - Check last bit==1, else end_err.
    - Short response CRC check: CRC over bits [47:8] must equal bits [7:1].
    - Long response CRC check: CRC over bits [127:8] (skip start, tx bit, 6 reserved bits) must equal [7:1].
    - -> NCC.
  - NCC: cmd_oe=1, cmd_out=1 for NCC_BITS strobes.
    - Then done=1 for exactly one clock, status valid that cycle; rsp_data held until the next accept.
    - -> IDLE; cmd_ready=1 the same cycle as done.
- bit_en=0 freezes all counters and the shifter; cmd_out/cmd_oe hold.
- cmd_valid while busy is ignored (not queued).

Optional Feature:
- SD_CMD_CRC_CHECK_EN. Defined: response CRC7 checked as above and crc_err reported.
- Undefined: no receive CRC logic; crc_err tied 0; end_err still checked.
- Transmit CRC7 is always present.

Test Plan:
- CMD0, arg 0x00000000, rsp_type 00, bit_en every cycle -> cmd_out serial 0x400000000095; no sampling; done after 48+NCC_BITS strobes; all flags 0.
- CMD8, arg 0x000001AA, rsp_type 01; card answers 0x08000001AA13 (valid CRC) after 5 idle bits -> rsp_data[47:0]=0x08000001AA13; crc_err=0; end_err=0; timeout=0.
- CMD2, rsp_type 10; card sends a 136-bit R2 with correct CRC -> full 136 bits captured, crc_err=0. Flip one payload bit -> crc_err=1 (with SD_CMD_CRC_CHECK_EN), crc_err=0 without.
- timeout_cycles=10, cmd_in held high -> timeout=1 with done on the 10th WAIT strobe; timeout_cycles=0 -> timeout after 1 strobe. Start bit on strobe 10 -> no timeout.
- bit_en asserted every 4th cycle; reset asserted during RX -> outputs return to reset values next cycle; no done; cmd_ready=1 after reset release.
- Short response with end bit 0 -> end_err=1. cmd_valid held high across done -> second command accepted on the done cycle.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: frames a command with CRC7, waits for the card's start bit and captures
// the response. Define SD_CMD_CRC_CHECK_EN to check the response CRC7 and report crc_err.
module sd_cmd_engine #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned NCC_BITS  = 8,
  parameter int unsigned TURN_BITS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bit_en,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          cmd_arg,
  input  logic [1:0]           rsp_type,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 cmd_out,
  output logic                 cmd_oe,
  input  logic                 cmd_in,
  output logic [135:0]         rsp_data,
  output logic                 done,
  output logic                 timeout,
  output logic                 crc_err,
  output logic                 end_err
);

  typedef enum logic [2:0] {StIdle, StTx, StTurn, StWait, StRx, StNcc} state_e;

  localparam int unsigned MaxA   = (NCC_BITS > 136) ? NCC_BITS : 136;
  localparam int unsigned MaxCnt = (TURN_BITS > MaxA) ? TURN_BITS : MaxA;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0]      CntOne   = CntW'(1);
  localparam logic [CntW-1:0]      TurnLast = CntW'(TURN_BITS - 1);
  localparam logic [CntW-1:0]      NccLast  = CntW'(NCC_BITS - 1);
  localparam logic [TIMEOUT_W-1:0] TmoOne   = TIMEOUT_W'(1);

  state_e                 state_q, state_d;
  logic                   rst_done_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   wcnt_q, wcnt_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [39:0]            tx_q, tx_d;
  logic [6:0]             crc_q, crc_d;
  logic [135:0]           rsp_q, rsp_d;
  logic                   long_q, long_d;
  logic                   has_rsp_q, has_rsp_d;
  logic                   out_q, out_d;
  logic                   oe_q, oe_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   end_err_q, end_err_d;
`ifdef SD_CMD_CRC_CHECK_EN
  logic                   crc_err_q, crc_err_d;
`endif

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign cmd_ready = rst_done_q && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    tx_d      = tx_q;
    crc_d     = crc_q;
    rsp_d     = rsp_q;
    long_d    = long_q;
    has_rsp_d = has_rsp_q;
    out_d     = out_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    end_err_d = end_err_q;
`ifdef SD_CMD_CRC_CHECK_EN
    crc_err_d = crc_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = StTx;
          tx_d      = {2'b01, cmd_index, cmd_arg};
          crc_d     = '0;
          cnt_d     = '0;
          rsp_d     = '0;
          long_d    = (rsp_type == 2'b10);
          has_rsp_d = (rsp_type != 2'b00);
          tmo_d     = (timeout_cycles == '0) ? TmoOne : timeout_cycles;
          timeout_d = 1'b0;
          end_err_d = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
          crc_err_d = 1'b0;
`endif
        end
      end
      StTx: begin
        if (bit_en) begin
          oe_d  = 1'b1;
          cnt_d = cnt_q + CntOne;
          if (cnt_q < CntW'(40)) begin
            out_d = tx_q[39];
            tx_d  = {tx_q[38:0], 1'b0};
            crc_d = crc7_step(crc_q, tx_q[39]);
          end else if (cnt_q < CntW'(47)) begin
            // CRC register is shifted out directly once the 40 payload bits are done
            out_d = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else begin
            out_d   = 1'b1;
            cnt_d   = '0;
            state_d = has_rsp_q ? StTurn : StNcc;
          end
        end
      end
      StTurn: begin
        if (bit_en) begin
          oe_d  = 1'b0;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == TurnLast) begin
            cnt_d   = '0;
            wcnt_d  = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bit_en) begin
          if (!cmd_in) begin
            state_d = StRx;
            rsp_d   = {rsp_q[134:0], 1'b0};
            crc_d   = '0;
            cnt_d   = CntOne;
          end else if (wcnt_q == tmo_q - TmoOne) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = StNcc;
          end else begin
            wcnt_d = wcnt_q + TmoOne;
          end
        end
      end
      StRx: begin
        if (bit_en) begin
          rsp_d = {rsp_q[134:0], cmd_in};
          cnt_d = cnt_q + CntOne;
`ifdef SD_CMD_CRC_CHECK_EN
          // Long responses skip start, direction and reserved bits in the CRC
          if ((cnt_q >= (long_q ? CntW'(8) : CntW'(0))) &&
              (cnt_q < (long_q ? CntW'(128) : CntW'(40)))) begin
            crc_d = crc7_step(crc_q, cmd_in);
          end
`endif
          if (cnt_q == (long_q ? CntW'(135) : CntW'(47))) begin
            end_err_d = ~cmd_in;
`ifdef SD_CMD_CRC_CHECK_EN
            crc_err_d = (crc_q != rsp_q[6:0]);
`endif
            cnt_d     = '0;
            state_d   = StNcc;
          end
        end
      end
      StNcc: begin
        if (bit_en) begin
          oe_d  = 1'b1;
          out_d = 1'b1;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == NccLast) begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      rst_done_q <= 1'b0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      tmo_q      <= TmoOne;
      tx_q       <= '0;
      crc_q      <= '0;
      rsp_q      <= '0;
      long_q     <= 1'b0;
      has_rsp_q  <= 1'b0;
      out_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      end_err_q  <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
      crc_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      tmo_q      <= tmo_d;
      tx_q       <= tx_d;
      crc_q      <= crc_d;
      rsp_q      <= rsp_d;
      long_q     <= long_d;
      has_rsp_q  <= has_rsp_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      end_err_q  <= end_err_d;
`ifdef SD_CMD_CRC_CHECK_EN
      crc_err_q  <= crc_err_d;
`endif
    end
  end

  assign cmd_out  = out_q;
  assign cmd_oe   = oe_q;
  assign rsp_data = rsp_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign end_err  = end_err_q;
`ifdef SD_CMD_CRC_CHECK_EN
  assign crc_err  = crc_err_q;
`else
  assign crc_err  = 1'b0;
`endif

endmodule
